fifo_burst_reader: RTL

Read-side engine for the single-clock FIFO. On a length command it pulls exactly that many words from the FIFO's show-ahead output. It forwards them through a one-entry output register onto a valid/ready stream, marking the final word with `out_last`. When the burst completes it reports a modular checksum. It sits between the FIFO's pull/empty/dataout port and any downstream consumer, and is the standard driver for FIFO read traffic in the bench.

---
 rtl/fifo_rd_pkg.sv | 7 +
 rtl/fifo_burst_reader_out_stage.sv | 28 ++
 rtl/fifo_burst_reader.sv | 82 ++++++++
 3 files changed

// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: shared state encoding and sizing helper for the FIFO burst reader.
package fifo_rd_pkg;
   typedef enum logic [1:0] {IDLE, READ, DRAIN} rd_state_t;
   function automatic int len_w(input int maxburst);
      return $clog2(maxburst + 1);
   endfunction
endpackage

// File: rtl/fifo_burst_reader_out_stage.sv
// out_stage: one-entry valid/ready register carrying a data word and its last flag.
module out_stage #(
   parameter int busw = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic [busw-1:0] load_data,
   input  logic            load_last,
   input  logic            ready,
   output logic            valid,
   output logic [busw-1:0] data,
   output logic            last
);
   // load is only raised when the slot is free or being accepted, so a held word never changes
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         valid <= 1'b0;
         data  <= '0;
         last  <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= load_data;
         last  <= load_last;
      end else if (ready) begin
         valid <= 1'b0;
      end
endmodule

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pulls a commanded number of words from a show-ahead FIFO onto a
// valid/ready stream, flags the final word and reports a modular checksum.
module fifo_burst_reader
   import fifo_rd_pkg::*;
#(
   parameter int busw = 32,
   parameter int maxburst = 16,
   localparam int lw = len_w(maxburst)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   input  logic [lw-1:0]   req_len,
   output logic            req_ready,
   input  logic            empty,
   input  logic [busw-1:0] fifo_data,
   output logic            pull,
   output logic            out_valid,
   output logic [busw-1:0] out_data,
   output logic            out_last,
   input  logic            out_ready,
   output logic            done,
   output logic [busw-1:0] csum
);
   rd_state_t state, state_nx;
   logic [lw-1:0] remain, len_c;
   logic [busw-1:0] acc;
   logic accept;
   assign len_c  = (req_len > lw'(maxburst)) ? lw'(maxburst) : req_len;
   assign accept = out_valid && out_ready;
   always_comb begin
      state_nx  = state;
      req_ready = state == IDLE;
      pull      = state == READ && !empty && remain != '0 && (!out_valid || out_ready);
      case (state)
         IDLE:    if (req_valid && len_c != '0) state_nx = READ;
         READ:    if (pull && remain == lw'(1)) state_nx = DRAIN;
         DRAIN:   if (accept && out_last) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= IDLE;
      else state <= state_nx;
   // a zero-length command completes on its own with an empty checksum
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         remain <= '0;
         acc    <= '0;
         done   <= 1'b0;
         csum   <= '0;
      end else begin
         done <= 1'b0;
         if (req_ready && req_valid) begin
            remain <= len_c;
            acc    <= '0;
            if (len_c == '0) begin
               done <= 1'b1;
               csum <= '0;
            end
         end
         if (pull) begin
            remain <= remain - lw'(1);
            acc    <= acc + fifo_data;
         end
         if (state == DRAIN && accept && out_last) begin
            done <= 1'b1;
            csum <= acc;
         end
      end
   out_stage #(.busw(busw)) u_out (
      .clk(clk),
      .rst(rst),
      .load(pull),
      .load_data(fifo_data),
      .load_last(remain == lw'(1)),
      .ready(out_ready),
      .valid(out_valid),
      .data(out_data),
      .last(out_last)
   );
endmodule
